// File: rtl/apb_dbg_xbar_pkg.sv
// rtl/apb_dbg_xbar_pkg.sv - shared types and helpers for the debug APB crossbar
package apb_dbg_xbar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam int ERR_CNT_W = 16;

    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_dbg_xbar_tmo.sv
// rtl/apb_dbg_xbar_tmo.sv - access timeout counter with load/enable and expiry flag
module apb_dbg_xbar_tmo
    import apb_dbg_xbar_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_load) begin
            cnt <= '0;
        end else if (i_en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Expiry is flagged during the cycle the count sits at LIMIT, so the
    // owning FSM aborts on the edge that closes the TIMEOUT_CYC-th cycle.
    assign o_expire = (TIMEOUT_CYC != 0) && i_en && (cnt == LIMIT);

endmodule

// File: rtl/apb_dbg_xbar.sv
// rtl/apb_dbg_xbar.sv - single-master debug APB crossbar with timeout and error counting
module apb_dbg_xbar
    import apb_dbg_xbar_pkg::*;
#(
    parameter int NUM_SLAVES  = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SEL_LSB     = 30,
    parameter int TIMEOUT_CYC = 1024,
    parameter logic [DATA_W-1:0] ERR_RDATA = DATA_W'(32'hDEAD_BEEF)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_penable,
    input  logic                         i_pwrite,
    input  logic [ADDR_W-1:0]            i_paddr,
    input  logic [DATA_W-1:0]            i_pwdata,
    output logic                         o_pready,
    output logic [DATA_W-1:0]            o_prdata,
    output logic                         o_pslverr,
    output logic [NUM_SLAVES-1:0]        o_s_penable,
    output logic                         o_s_pwrite,
    output logic [ADDR_W-1:0]            o_s_paddr,
    output logic [DATA_W-1:0]            o_s_pwdata,
    input  logic [NUM_SLAVES-1:0]        i_s_pready,
    input  logic [NUM_SLAVES*DATA_W-1:0] i_s_prdata,
    output logic                         o_timeout,
    output logic [ERR_CNT_W-1:0]         o_err_cnt
);

    localparam int SEL_W = sel_w(NUM_SLAVES);
    localparam logic [NUM_SLAVES-1:0] ONE_HOT0 = NUM_SLAVES'(1);

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic [SEL_W-1:0] idx;
    logic             sel_mapped;
    logic             sel_ready;
    logic [DATA_W-1:0] sel_rdata;
    logic             tmo_expire;
    logic [DATA_W-1:0] s_rdata [NUM_SLAVES];

    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_rdata
        assign s_rdata[k] = i_s_prdata[k*DATA_W +: DATA_W];
    end

    assign sel        = i_paddr[SEL_LSB +: SEL_W];
    assign sel_mapped = (int'(sel) < NUM_SLAVES);
    assign sel_ready  = i_s_pready[idx];
    assign sel_rdata  = s_rdata[idx];

    apb_dbg_xbar_tmo #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (state == IDLE),
        .i_en     (state == ACCESS),
        .o_expire (tmo_expire)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            idx         <= '0;
            o_pready    <= 1'b0;
            o_prdata    <= '0;
            o_pslverr   <= 1'b0;
            o_s_penable <= '0;
            o_s_pwrite  <= 1'b0;
            o_s_paddr   <= '0;
            o_s_pwdata  <= '0;
            o_timeout   <= 1'b0;
            o_err_cnt   <= '0;
        end else begin
            o_pready  <= 1'b0;
            o_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_penable) begin
                        o_s_pwrite <= i_pwrite;
                        o_s_paddr  <= i_paddr;
                        o_s_pwdata <= i_pwdata;
                        idx        <= sel;
                        if (sel_mapped) begin
                            o_s_penable <= ONE_HOT0 << sel;
                            state       <= ACCESS;
                        end else begin
                            o_prdata  <= ERR_RDATA;
                            o_pslverr <= 1'b1;
                            o_pready  <= 1'b1;
                            if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
                            state     <= RESP;
                        end
                    end
                end
                ACCESS: begin
                    // Slave ready takes priority over a coincident expiry.
                    if (sel_ready) begin
                        o_s_penable <= '0;
                        o_prdata    <= o_s_pwrite ? '0 : sel_rdata;
                        o_pslverr   <= 1'b0;
                        o_pready    <= 1'b1;
                        state       <= RESP;
                    end else if (tmo_expire) begin
                        o_s_penable <= '0;
                        o_prdata    <= ERR_RDATA;
                        o_pslverr   <= 1'b1;
                        o_pready    <= 1'b1;
                        o_timeout   <= 1'b1;
                        if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + ERR_CNT_W'(1);
                        state       <= RESP;
                    end
                end
                RESP: begin
                    state <= DRAIN;
                end
                DRAIN: begin
                    if (!i_penable) state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_dbg_xbar.sv
// tb/tb_apb_dbg_xbar.sv - scoreboard bench for the debug APB crossbar
module tb_apb_dbg_xbar;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwrite = 1'b0;
    logic [31:0] paddr = '0;
    logic [31:0] pwdata = '0;

    logic         penable_a = 1'b0;
    logic [3:0]   pready_a = '0;
    logic [127:0] prdata_a = '0;
    logic         a_pready, a_pslverr, a_s_pwrite, a_timeout;
    logic [31:0]  a_prdata, a_s_paddr, a_s_pwdata;
    logic [3:0]   a_s_penable;
    logic [15:0]  a_err_cnt;

    logic         penable_b = 1'b0;
    logic [2:0]   pready_b = '0;
    logic [95:0]  prdata_b = '0;
    logic         b_pready, b_pslverr, b_s_pwrite, b_timeout;
    logic [31:0]  b_prdata, b_s_paddr, b_s_pwdata;
    logic [2:0]   b_s_penable;
    logic [15:0]  b_err_cnt;

    int checks = 0;
    int failures = 0;
    int resp_a = 0;
    int resp_b = 0;
    int base;
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;

    always #5 clk = ~clk;

    apb_dbg_xbar #(
        .NUM_SLAVES(4), .ADDR_W(32), .DATA_W(32), .SEL_LSB(30), .TIMEOUT_CYC(8)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_penable(penable_a), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_pready(a_pready), .o_prdata(a_prdata),
        .o_pslverr(a_pslverr), .o_s_penable(a_s_penable), .o_s_pwrite(a_s_pwrite),
        .o_s_paddr(a_s_paddr), .o_s_pwdata(a_s_pwdata), .i_s_pready(pready_a),
        .i_s_prdata(prdata_a), .o_timeout(a_timeout), .o_err_cnt(a_err_cnt)
    );

    apb_dbg_xbar #(
        .NUM_SLAVES(3), .ADDR_W(32), .DATA_W(32), .SEL_LSB(30), .TIMEOUT_CYC(4)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_penable(penable_b), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata), .o_pready(b_pready), .o_prdata(b_prdata),
        .o_pslverr(b_pslverr), .o_s_penable(b_s_penable), .o_s_pwrite(b_s_pwrite),
        .o_s_paddr(b_s_paddr), .o_s_pwdata(b_s_pwdata), .i_s_pready(pready_b),
        .i_s_prdata(prdata_b), .o_timeout(b_timeout), .o_err_cnt(b_err_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (a_pready === 1'b1) begin
            resp_a++;
            if (exp_a.size() == 0) begin
                check_eq("a_unexpected_pready", 1, 0);
            end else begin
                ea = exp_a.pop_front();
                check_eq("a_prdata", a_prdata, ea.rdata);
                check_eq("a_pslverr", a_pslverr, ea.err);
            end
        end
        if (b_pready === 1'b1) begin
            resp_b++;
            if (exp_b.size() == 0) begin
                check_eq("b_unexpected_pready", 1, 0);
            end else begin
                eb = exp_b.pop_front();
                check_eq("b_prdata", b_prdata, eb.rdata);
                check_eq("b_pslverr", b_pslverr, eb.err);
            end
        end
    end

    initial begin
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_pready", a_pready, 0);
        check_eq("rst_prdata", a_prdata, 0);
        check_eq("rst_s_penable", a_s_penable, 0);
        check_eq("rst_s_paddr", a_s_paddr, 0);
        check_eq("rst_err_cnt", a_err_cnt, 0);
        check_eq("rst_timeout", a_timeout, 0);

        // zero-wait read from slave 2
        tick(1);
        base = resp_a;
        prdata_a[64 +: 32] = 32'h1234_5678;
        pready_a = 4'b0100;
        paddr = 32'h8000_0010;
        pwrite = 1'b0;
        penable_a = 1'b1;
        exp_a.push_back('{32'h1234_5678, 1'b0});
        @(negedge clk);
        @(negedge clk);
        check_eq("zw_s_penable", a_s_penable, 4'b0100);
        check_eq("zw_s_paddr", a_s_paddr, 32'h8000_0010);
        @(negedge clk);
        check_eq("zw_pready_c2", a_pready, 1);
        repeat (5) @(negedge clk);
        tick(1);
        check_eq("zw_single_pulse", resp_a, base + 1);
        penable_a = 1'b0;
        pready_a = '0;
        tick(2);

        // wait-state write to slave 1
        pwrite = 1'b1;
        paddr = 32'h4000_0000;
        pwdata = 32'hA5A5_A5A5;
        penable_a = 1'b1;
        exp_a.push_back('{32'h0, 1'b0});
        @(negedge clk);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            check_eq("ws_s_penable", a_s_penable, 4'b0010);
            check_eq("ws_s_pwdata", a_s_pwdata, 32'hA5A5_A5A5);
            if (i == 1) pwdata = 32'h0;
            if (i == 7) pready_a = 4'b0010;
        end
        @(negedge clk);
        check_eq("ws_pready", a_pready, 1);
        check_eq("ws_s_penable_off", a_s_penable, 0);
        tick(1);
        pready_a = '0;
        penable_a = 1'b0;
        tick(2);

        // timeout on slave 0
        pwrite = 1'b0;
        paddr = 32'h0000_0100;
        penable_a = 1'b1;
        exp_a.push_back('{32'hDEAD_BEEF, 1'b1});
        @(negedge clk);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check_eq("to_s_penable", a_s_penable, 4'b0001);
            check_eq("to_no_early_timeout", a_timeout, 0);
        end
        @(negedge clk);
        check_eq("to_s_penable_off", a_s_penable, 0);
        check_eq("to_timeout_pulse", a_timeout, 1);
        check_eq("to_err_cnt", a_err_cnt, 1);
        @(negedge clk);
        check_eq("to_timeout_single", a_timeout, 0);
        tick(1);
        penable_a = 1'b0;
        tick(2);

        // unmapped select on the 3-slave instance
        paddr = 32'hC000_0000;
        penable_b = 1'b1;
        exp_b.push_back('{32'hDEAD_BEEF, 1'b1});
        @(negedge clk);
        @(negedge clk);
        check_eq("um_pready_c1", b_pready, 1);
        check_eq("um_s_penable", b_s_penable, 0);
        check_eq("um_err_cnt", b_err_cnt, 1);
        tick(1);
        penable_b = 1'b0;
        tick(2);

        // ready arriving on the expiring edge
        paddr = 32'h4000_0000;
        prdata_b[32 +: 32] = 32'hCAFE_F00D;
        penable_b = 1'b1;
        exp_b.push_back('{32'hCAFE_F00D, 1'b0});
        @(negedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check_eq("race_s_penable", b_s_penable, 3'b010);
            if (i == 4) pready_b = 3'b010;
        end
        @(negedge clk);
        check_eq("race_pready", b_pready, 1);
        check_eq("race_no_timeout", b_timeout, 0);
        check_eq("race_err_cnt", b_err_cnt, 1);
        tick(1);
        pready_b = '0;
        penable_b = 1'b0;
        tick(2);

        // reset during a stalled access, then a clean read
        base = resp_a;
        paddr = 32'h8000_0000;
        penable_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tick(1);
        rst = 1'b1;
        penable_a = 1'b0;
        @(negedge clk);
        check_eq("mr_s_penable_c3", a_s_penable, 4'b0100);
        @(negedge clk);
        check_eq("mr_s_penable_off", a_s_penable, 0);
        check_eq("mr_pready", a_pready, 0);
        check_eq("mr_err_cnt", a_err_cnt, 0);
        tick(1);
        rst = 1'b0;
        tick(1);
        check_eq("mr_no_resp", resp_a, base);
        prdata_a[64 +: 32] = 32'h1111_2222;
        pready_a = 4'b0100;
        penable_a = 1'b1;
        exp_a.push_back('{32'h1111_2222, 1'b0});
        repeat (4) @(negedge clk);
        tick(1);
        check_eq("mr_new_read", resp_a, base + 1);
        penable_a = 1'b0;
        pready_a = '0;
        tick(2);

        check_eq("a_queue_drained", exp_a.size(), 0);
        check_eq("b_queue_drained", exp_b.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_dbg_xbar.md
Name: apb_dbg_xbar

Overview:
Parametrised successor to the fixed 3-way debug-bus decode in the CPU top. It routes one APB-style debug master (the dbg UART bridge) to NUM_SLAVES slaves using a configurable address select field. It adds behaviour the fixed decode lacks:
- registered single-transaction sequencing;
- per-access timeout with slave abort;
- error response for unmapped or timed-out accesses;
- a saturating error counter.

Parameters:
- NUM_SLAVES, 4, number of slave ports (2..16)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- SEL_LSB, 30, lowest bit of the slave-select field; field width SEL_W = clog2(NUM_SLAVES), occupying paddr[SEL_LSB+SEL_W-1:SEL_LSB]
- TIMEOUT_CYC, 1024, ACCESS cycles before abort; 0 disables timeout
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on error

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_penable  in  1  master request level, held until the transaction is done
- i_pwrite  in  1  master write flag
- i_paddr  in  ADDR_W  master address
- i_pwdata  in  DATA_W  master write data
- o_pready  out  1  one-cycle completion pulse
- o_prdata  out  DATA_W  read data, valid while o_pready=1
- o_pslverr  out  1  error flag, valid while o_pready=1
- o_s_penable  out  NUM_SLAVES  per-slave enable, one-hot or zero
- o_s_pwrite  out  1  registered pwrite, shared by all slaves
- o_s_paddr  out  ADDR_W  registered address, shared
- o_s_pwdata  out  DATA_W  registered write data, shared
- i_s_pready  in  NUM_SLAVES  per-slave ready
- i_s_prdata  in  NUM_SLAVES*DATA_W  per-slave read data; slave k occupies bits [k*DATA_W +: DATA_W]
- o_timeout  out  1  one-cycle pulse on abort
- o_err_cnt  out  16  saturating count of error responses

Behaviour:
- Reset (edge with i_rst=1): state IDLE. All outputs go to 0: o_pready, o_prdata, o_pslverr, o_s_penable, o_s_pwrite, o_s_paddr, o_s_pwdata, o_timeout, o_err_cnt. Timeout counter cleared.
- Reset mid-transaction: o_s_penable drops at that edge; no response is issued.
- States: IDLE, ACCESS, RESP, DRAIN.
- IDLE:
  - Entered from reset, or from DRAIN.
  - On an edge with i_penable=1: capture pwrite, paddr and pwdata into the o_s_* registers, decode idx from the select field.
  - If idx < NUM_SLAVES: go to ACCESS and set o_s_penable[idx]=1.
  - Otherwise (unmapped index): go to RESP with o_pslverr=1, o_prdata=ERR_RDATA, and no slave enabled.
- ACCESS:
  - o_s_penable[idx] is held high and o_s_* stay stable.
  - On an edge with i_s_pready[idx]=1: drop the enable, capture i_s_prdata[idx] into o_prdata, set o_pslverr=0, go to RESP.
  - Otherwise the counter increments. If TIMEOUT_CYC≠0 and the counter reaches TIMEOUT_CYC-1 on an edge: drop the enable, o_prdata=ERR_RDATA, o_pslverr=1, o_timeout=1 for one cycle, go to RESP.
  - If pready and timeout occur on the same edge, pready wins and there is no error.
  - Write accesses set o_prdata=0.
- RESP:
  - Exactly one cycle with o_pready=1.
  - o_err_cnt increments on entry to RESP when an error is flagged; it saturates at 16'hFFFF.
  - Then go to DRAIN.
- DRAIN:
  - o_pready=0, o_prdata held.
  - Stay until i_penable=0 is sampled, then go to IDLE. This guarantees one access per master request.
- Latency: for a zero-wait slave (i_s_pready combinationally high), i_penable rising in cycle 0 gives ACCESS in cycle 1 and o_pready in cycle 2. An unmapped access gives o_pready in cycle 1.
- i_paddr, i_pwrite and i_pwdata changes after capture are ignored.
- Counter width: clog2(TIMEOUT_CYC+1). It is cleared on every entry to ACCESS.

Decomposition:
- Package apb_dbg_xbar_pkg:
  - state enum (IDLE/ACCESS/RESP/DRAIN);
  - ERR_CNT_W=16;
  - function sel_w(n) = clog2(n).
- One sub-module, apb_dbg_xbar_tmo: load/enable timeout counter, parametrised by TIMEOUT_CYC, output o_expire. It ties o_expire=0 when TIMEOUT_CYC=0.

Test Plan:
- Zero-wait read: NUM_SLAVES=4, SEL_LSB=30, paddr=32'h8000_0010, slave2 prdata=32'h1234_5678, slave2 pready=1 → o_s_penable=4'b0100 in cycle 1; o_pready=1 in cycle 2 with o_prdata=32'h1234_5678 and o_pslverr=0; exactly one pulse while i_penable stays high for 5 more cycles.
- Wait-state write: paddr=32'h4000_0000, pwdata=32'hA5A5_A5A5, slave1 pready delayed 7 cycles → o_s_pwdata stable throughout, o_s_penable=4'b0010 for 7 cycles, o_pready one cycle later, o_prdata=0.
- Timeout: TIMEOUT_CYC=8, slave0 never ready → o_s_penable low after 8 ACCESS cycles, o_timeout pulses, o_pready with o_pslverr=1 and o_prdata=32'hDEAD_BEEF, o_err_cnt=1.
- Unmapped: NUM_SLAVES=3, select field = 3 → o_pready in cycle 1, o_pslverr=1, no o_s_penable bit set.
- Same-edge race: TIMEOUT_CYC=4, pready asserted on the expiring edge → o_pslverr=0, real data returned, no o_timeout pulse.
- Reset mid-ACCESS: i_rst=1 on cycle 3 of a stalled access → o_s_penable=0 and state IDLE after that edge, no o_pready. After reset, a new read completes normally.
